wave_sequencer: RTL and testbench
=================================

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the sample width (MAX = 2^WIDTH-1).
REQ-002 The block SHALL have parameter DIV_W, default 4, giving the prescaler divide-control width.
REQ-003 The block SHALL have port clk, input, 1, the clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, the run enable; low freezes all state except mode tracking.
REQ-006 The block SHALL have port mode, input, 2, selecting 00 ZERO, 01 SAW_UP, 10 SAW_DOWN or 11 TRIANGLE.
REQ-007 The block SHALL have port step, input, WIDTH, the increment per tick; 0 is treated as 1.
REQ-008 The block SHALL have port div, input, DIV_W, so that a tick occurs every div+1 enabled cycles.
REQ-009 The block SHALL have port count, output, WIDTH, the registered waveform sample.
REQ-010 The block SHALL have port up, output, 1, the registered direction (1 = rising).
REQ-011 The block SHALL have port period_start, output, 1, a one-cycle registered pulse at each period boundary.

Function
REQ-012 The prescaler SHALL increment pre on each cycle with en=1, assert tick when pre >= div and clear pre to 0 that cycle; a div change mid-count therefore never stalls.
REQ-013 When en=0, pre, count, up and period_start SHALL hold; period_start is forced to 0.
REQ-014 A mode_q register SHALL capture mode every cycle; when mode != mode_q, in that cycle regardless of en: pre cleared, count loaded (ZERO->0, SAW_UP->0, SAW_DOWN->MAX, TRIANGLE->unchanged), up loaded (SAW_DOWN->0, others->1), period_start=1.
REQ-015 In ZERO, count SHALL be 0 and up SHALL be 1 on every cycle, and no ticks SHALL take effect.
REQ-016 In SAW_UP, on a tick, count SHALL become 0 with period_start=1 if count+step > MAX (computed WIDTH+1 bits); otherwise it SHALL become count+step.
REQ-017 In SAW_DOWN, on a tick, count SHALL become MAX with period_start=1 if count < step; otherwise it SHALL become count-step.
REQ-018 In TRIANGLE with up=1, on a tick, count SHALL saturate to MAX and up SHALL become 0 if count+step >= MAX; otherwise it SHALL become count+step.
REQ-019 In TRIANGLE with up=0, on a tick, count SHALL become 0, up SHALL become 1 and period_start SHALL be 1 if count <= step; otherwise it SHALL become count-step.
REQ-020 Apart from REQ-014, period_start SHALL be 0 on every cycle without a boundary event.
REQ-021 Outputs SHALL update one cycle after the tick cycle, with no combinational input-to-output path.
REQ-022 A mode change SHALL take priority over a coincident tick.

Reset
REQ-023 While reset=1, the block SHALL set count=0, up=1, period_start=0, pre=0 and mode_q=ZERO, overriding en and mode.
REQ-024 A reset mid-period SHALL abandon the period, and on the first cycle after reset a mode other than ZERO SHALL trigger the REQ-014 mode-change load.

Structure
REQ-025 Package wave_pkg SHALL hold the mode enum (MODE_ZERO, MODE_SAW_UP, MODE_SAW_DOWN, MODE_TRIANGLE with encodings 00/01/10/11) and the UP=1/DOWN=0 constants.
REQ-026 The prescaler SHALL be the single sub-module tick_prescaler (params DIV_W; ports clk, reset, en, clr, div, tick).

Verification
REQ-027 The bench SHALL cover: WIDTH=5, TRIANGLE, step=1, div=0 -> count 0..31..0, up falls on the cycle count reaches 31, period_start once per 62 cycles.
REQ-028 The bench SHALL cover: TRIANGLE, step=7, div=0 from 0 -> 7,14,21,28,31,24,17,10,3,0,7, saturating at both ends.
REQ-029 The bench SHALL cover: SAW_UP, step=10, div=2 -> count changes every 3 cycles as 0,10,20,30,0, with period_start on the wrap.
REQ-030 The bench SHALL cover: SAW_DOWN, step=0 -> behaves as step=1, 31..0 then 31, with period_start on the reload to 31.
REQ-031 The bench SHALL cover: TRIANGLE at count=12 descending, switch to SAW_DOWN -> next cycle count=31, up=0, period_start=1, pre=0.
REQ-032 The bench SHALL cover: en=0 for 5 cycles mid-ramp, then reset asserted mid-period -> values frozen during en=0, then count=0, up=1 and period_start=0 the cycle after reset.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types for the waveform sequencer.
// Mode encoding and direction constants.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO     = 2'b00,
        MODE_SAW_UP   = 2'b01,
        MODE_SAW_DOWN = 2'b10,
        MODE_TRIANGLE = 2'b11
    } mode_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: one tick every div+1 enabled cycles.
// Uses >= so a smaller div written mid-count fires at once.
module tick_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] pre;

    // Tick is combinational on the current count; gated by enable.
    always_comb begin
        tick = en && (pre >= div);
    end

    // Count enabled cycles; restart on tick or on external clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + ONE;
            end
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Programmable waveform sequencer: zero, saw up, saw down, triangle.
// The tracked mode register acts as the FSM state.
module wave_sequencer
    import wave_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             up,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   MAXW = {1'b0, MAX};

    mode_e            mode_q;
    mode_e            mode_d;
    logic             mode_chg;
    logic             tick;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] count_d;
    logic             up_d;
    logic             ps_d;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (mode_chg),
        .div   (div),
        .tick  (tick)
    );

    // Step arithmetic; a zero step behaves as one, sum has a carry bit.
    always_comb begin
        mode_d   = mode_e'(mode);
        mode_chg = (mode_d != mode_q);
        step_eff = (step == '0) ? ONE : step;
        sum      = {1'b0, count} + {1'b0, step_eff};
        diff     = count - step_eff;
    end

    // Next-state: mode change beats tick; disabled cycles hold.
    always_comb begin
        count_d = count;
        up_d    = up;
        ps_d    = 1'b0;
        if (mode_chg) begin
            ps_d = 1'b1;
            unique case (mode_d)
                MODE_ZERO: begin
                    count_d = '0;
                    up_d    = UP;
                end
                MODE_SAW_UP: begin
                    count_d = '0;
                    up_d    = UP;
                end
                MODE_SAW_DOWN: begin
                    count_d = MAX;
                    up_d    = DOWN;
                end
                MODE_TRIANGLE: begin
                    up_d    = UP;
                end
            endcase
        end else if (en) begin
            unique case (mode_q)
                MODE_ZERO: begin
                    count_d = '0;
                    up_d    = UP;
                end
                MODE_SAW_UP: begin
                    if (tick) begin
                        if (sum > MAXW) begin
                            count_d = '0;
                            ps_d    = 1'b1;
                        end else begin
                            count_d = sum[WIDTH-1:0];
                        end
                    end
                end
                MODE_SAW_DOWN: begin
                    if (tick) begin
                        if (count < step_eff) begin
                            count_d = MAX;
                            ps_d    = 1'b1;
                        end else begin
                            count_d = diff;
                        end
                    end
                end
                MODE_TRIANGLE: begin
                    if (tick) begin
                        if (up == UP) begin
                            if (sum >= MAXW) begin
                                count_d = MAX;
                                up_d    = DOWN;
                            end else begin
                                count_d = sum[WIDTH-1:0];
                            end
                        end else begin
                            if (count <= step_eff) begin
                                count_d = '0;
                                up_d    = UP;
                                ps_d    = 1'b1;
                            end else begin
                                count_d = diff;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_ZERO;
            count        <= '0;
            up           <= UP;
            period_start <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            count        <= count_d;
            up           <= up_d;
            period_start <= ps_d;
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer with a cycle-level reference
// model and hand-computed waypoints.
module tb_wave_sequencer;

    localparam int MAXV = 31;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [4:0] step;
    logic [3:0] div;
    logic [4:0] count;
    logic       up;
    logic       period_start;

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    // reference model state (plain integers)
    int m_count = 0;
    int m_up = 1;
    int m_ps = 0;
    int m_pre = 0;
    int m_mq = 0;
    int m_st;
    bit m_t;

    wave_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .step         (step),
        .div          (div),
        .count        (count),
        .up           (up),
        .period_start (period_start)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: waveform rules in integer arithmetic.
    always @(posedge clk) begin
        m_st = (step == 0) ? 1 : int'(step);
        if (reset) begin
            m_count = 0; m_up = 1; m_ps = 0; m_pre = 0; m_mq = 0;
        end else if (int'(mode) != m_mq) begin
            m_mq = int'(mode);
            m_pre = 0;
            m_ps = 1;
            m_up = (m_mq == 2) ? 0 : 1;
            if (m_mq == 0 || m_mq == 1) m_count = 0;
            else if (m_mq == 2) m_count = MAXV;
        end else if (!en) begin
            m_ps = 0;
        end else begin
            m_t = (m_pre >= int'(div));
            m_pre = m_t ? 0 : m_pre + 1;
            m_ps = 0;
            if (m_mq == 0) begin
                m_count = 0; m_up = 1;
            end else if (m_t && m_mq == 1) begin
                if (m_count + m_st > MAXV) begin
                    m_count = 0; m_ps = 1;
                end else m_count = m_count + m_st;
            end else if (m_t && m_mq == 2) begin
                if (m_count < m_st) begin
                    m_count = MAXV; m_ps = 1;
                end else m_count = m_count - m_st;
            end else if (m_t && m_mq == 3) begin
                if (m_up == 1) begin
                    if (m_count + m_st >= MAXV) begin
                        m_count = MAXV; m_up = 0;
                    end else m_count = m_count + m_st;
                end else begin
                    if (m_count <= m_st) begin
                        m_count = 0; m_up = 1; m_ps = 1;
                    end else m_count = m_count - m_st;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_count", int'(count), m_count);
            check("model_up", int'(up), m_up);
            check("model_ps", int'(period_start), m_ps);
        end
    end

    int exp28[11] = '{7, 14, 21, 28, 31, 24, 17, 10, 3, 0, 7};
    int exp29[12] = '{0, 0, 10, 10, 10, 20, 20, 20, 30, 30, 30, 0};

    initial begin
        int pulses;
        bit found;
        reset = 1; en = 1; mode = 2'b11; step = 5'd1; div = 4'd0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        check("rst_count", int'(count), 0);
        check("rst_up", int'(up), 1);
        check("rst_ps", int'(period_start), 0);

        // triangle, step 1: full 0..31..0 sweep
        reset = 0;
        @(negedge clk);
        check("tri1_start_ps", int'(period_start), 1);
        check("tri1_start_cnt", int'(count), 0);
        repeat (30) @(negedge clk);
        check("tri1_30_cnt", int'(count), 30);
        check("tri1_30_up", int'(up), 1);
        @(negedge clk);
        check("tri1_peak_cnt", int'(count), 31);
        check("tri1_peak_up", int'(up), 0);
        repeat (31) @(negedge clk);
        check("tri1_floor_cnt", int'(count), 0);
        check("tri1_floor_ps", int'(period_start), 1);
        pulses = 0;
        repeat (62) begin
            @(negedge clk);
            pulses += int'(period_start);
        end
        check("tri1_pulses", pulses, 1);

        // triangle, step 7, saturating both ends
        mode = 2'b00;
        @(negedge clk);
        check("zero_cnt", int'(count), 0);
        mode = 2'b11; step = 5'd7;
        @(negedge clk);
        check("tri7_start_cnt", int'(count), 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("tri7_seq", int'(count), exp28[i]);
        end

        // saw up, step 10, div 2
        mode = 2'b01; step = 5'd10; div = 4'd2;
        @(negedge clk);
        check("saw_start_cnt", int'(count), 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("saw_seq", int'(count), exp29[k]);
            check("saw_ps", int'(period_start), (k == 11) ? 1 : 0);
        end

        // saw down, step 0 acts as 1
        mode = 2'b10; step = 5'd0; div = 4'd0;
        @(negedge clk);
        check("sd_start_cnt", int'(count), 31);
        check("sd_start_up", int'(up), 0);
        repeat (31) @(negedge clk);
        check("sd_floor_cnt", int'(count), 0);
        @(negedge clk);
        check("sd_wrap_cnt", int'(count), 31);
        check("sd_wrap_ps", int'(period_start), 1);

        // triangle descending at 12, switch to saw down
        mode = 2'b11; step = 5'd1; div = 4'd1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (m_count == 12 && m_up == 0) found = 1;
        end
        check("tri_find12", int'(found), 1);
        @(negedge clk);
        check("tri12_cnt", int'(count), 12);
        mode = 2'b10;
        @(negedge clk);
        check("sw_cnt", int'(count), 31);
        check("sw_up", int'(up), 0);
        check("sw_ps", int'(period_start), 1);
        check("sw_pre", int'(dut.u_pre.pre), 0);
        @(negedge clk);
        check("sw_hold", int'(count), 31);
        @(negedge clk);
        check("sw_step", int'(count), 30);

        // freeze with en=0, then reset mid-period
        mode = 2'b01; step = 5'd3; div = 4'd0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("frz_pre_cnt", int'(count), 12);
        en = 0;
        repeat (5) begin
            @(negedge clk);
            check("frz_cnt", int'(count), 12);
            check("frz_ps", int'(period_start), 0);
        end
        en = 1;
        @(negedge clk);
        check("frz_resume", int'(count), 15);
        reset = 1;
        @(negedge clk);
        check("mid_rst_cnt", int'(count), 0);
        check("mid_rst_up", int'(up), 1);
        check("mid_rst_ps", int'(period_start), 0);
        reset = 0;
        @(negedge clk);
        check("post_rst_ps", int'(period_start), 1);
        @(negedge clk);
        check("post_rst_cnt", int'(count), 3);

        // mode change while disabled, then zero mode ignores ticks
        en = 0; mode = 2'b10;
        @(negedge clk);
        check("dis_chg_cnt", int'(count), 31);
        check("dis_chg_ps", int'(period_start), 1);
        @(negedge clk);
        check("dis_hold_ps", int'(period_start), 0);
        en = 1; mode = 2'b00;
        @(negedge clk);
        check("z_chg_ps", int'(period_start), 1);
        repeat (3) @(negedge clk);
        check("z_cnt", int'(count), 0);
        check("z_up", int'(up), 1);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
